// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides and NZCV flags.
// Most commands complete in one cycle. MUL is an iterative shift-add that occupies
// the block for WIDTH cycles. Only one operation is in flight at a time, and the
// output register holds its contents until the consumer takes them.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       cmd,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] LAST_CNT = SH_W'(WIDTH - 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_MUL  = 4'b0001;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_LSL  = 4'b1000;
    localparam logic [3:0] CMD_ASR  = 4'b1001;
    localparam logic [3:0] CMD_LSR  = 4'b1010;
    localparam logic [3:0] CMD_MOVA = 4'b1100;
    localparam logic [3:0] CMD_MOVB = 4'b1101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0] mul_tag_q, mul_tag_d;

    // Single-cycle datapath results
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    logic             accept;
    logic             is_mul_cmd;
    logic             big_shift;
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH-1:0] mul_acc_next;

    // The shift amount is the whole of in2. Because WIDTH is a power of two,
    // "amount >= WIDTH" reduces to "any bit above the index field is set".
    assign big_shift = |in2[WIDTH-1:SH_W];
    assign sh_amt    = in2[SH_W-1:0];

    assign is_mul_cmd = (MUL_EN != 1'b0) && (cmd == CMD_MUL);
    assign in_ready   = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign out_tag   = out_tag_q;

    // Single-cycle operations: result plus carry/overflow, or illegal-command detection.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (cmd)
            CMD_ADD: begin
                {alu_c, alu_res} = {1'b0, in1} + {1'b0, in2};
                alu_v = (in1[MSB] == in2[MSB]) && (alu_res[MSB] != in1[MSB]);
            end
            CMD_MUL: begin
                // Result comes from the iterative path; this is illegal only when MUL is disabled.
                alu_err = (MUL_EN == 1'b0);
            end
            CMD_SUB: begin
                alu_res = in1 - in2;
                alu_c   = (in1 >= in2);
                alu_v   = (in1[MSB] != in2[MSB]) && (alu_res[MSB] != in1[MSB]);
            end
            CMD_AND:  alu_res = in1 & in2;
            CMD_OR:   alu_res = in1 | in2;
            CMD_NOR:  alu_res = ~(in1 | in2);
            CMD_XOR:  alu_res = in1 ^ in2;
            CMD_LSL:  alu_res = big_shift ? '0 : (in1 << sh_amt);
            CMD_ASR:  alu_res = big_shift ? {WIDTH{in1[MSB]}}
                                          : $unsigned($signed(in1) >>> sh_amt);
            CMD_LSR:  alu_res = big_shift ? '0 : (in1 >> sh_amt);
            CMD_MOVA: alu_res = in1;
            CMD_MOVB: alu_res = in2;
            default:  alu_err = 1'b1;
        endcase
    end

    // Next-state and next-register values for the FSM, the output register and the multiplier.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        err_d       = err_q;
        out_tag_d   = out_tag_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_tag_d   = mul_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_cmd) begin
                        state_d   = S_MUL;
                        mcand_d   = in1;
                        mplier_d  = in2;
                        acc_d     = '0;
                        cnt_d     = '0;
                        mul_tag_d = in_tag;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_err ? '0 : alu_res;
                        flags_d     = alu_err ? 4'b0000
                                              : {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
                        err_d       = alu_err;
                        out_tag_d   = in_tag;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SH_W'(1);
                // The last step's partial sum goes straight into the output register.
                if (cnt_q == LAST_CNT) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_acc_next;
                    flags_d     = {mul_acc_next[MSB], ~|mul_acc_next, 2'b00};
                    err_d       = 1'b0;
                    out_tag_d   = mul_tag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register: cleared on reset so a pending result is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            err_q       <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Multiplier working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mul_tag_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mul_tag_q <= mul_tag_d;
        end
    end

endmodule
